// File: rtl/barrel_arb_pkg.sv
// Shared constants and state encoding for barrel_arbiter and its shifter.
package barrel_arb_pkg;

  localparam int DATA_W    = 8;
  localparam int SHIFT_MAX = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/barrel_shifter_gate.sv
// Combinational logical-left barrel shifter, zero fill, 0..7 positions per pass.
module barrel_shifter_gate
  import barrel_arb_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [2:0]        amt,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] stage1_s;
  logic [DATA_W-1:0] stage2_s;

  // Three log-stages: shift by 1, 2, then 4.
  always_comb begin
    stage1_s = amt[0] ? {data[DATA_W-2:0], 1'b0}       : data;
    stage2_s = amt[1] ? {stage1_s[DATA_W-3:0], 2'b00}  : stage1_s;
    result   = amt[2] ? {stage2_s[DATA_W-5:0], 4'b0000} : stage2_s;
  end

endmodule

// File: rtl/barrel_arbiter.sv
// Two-requester round-robin scheduler around one barrel_shifter_gate, multi-pass shifts.
// Define BARREL_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module barrel_arbiter
  import barrel_arb_pkg::*;
#(
  parameter int AMT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  input  logic [AMT_W-1:0]  req_amt0,
  input  logic [AMT_W-1:0]  req_amt1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_id,
  output logic              busy
);

  state_e            state_r, state_nxt_s;
  logic [DATA_W-1:0] op_r;
  logic [AMT_W-1:0]  rem_r;
  logic              id_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_id_r;
  logic              busy_r;

  logic              grant_s;
  logic              accept_s;
  logic              last_pass_s;
  logic [2:0]        step_s;
  logic [DATA_W-1:0] shift_res_s;
  logic [DATA_W-1:0] req_data_s;
  logic [AMT_W-1:0]  req_amt_s;

`ifdef BARREL_ARB_FIXED_PRIO_EN
  // Fixed priority: requester 0 whenever it is valid.
  always_comb begin
    if (req_valid[0]) begin
      grant_s = 1'b0;
    end else begin
      grant_s = req_valid[1];
    end
  end
`else
  logic last_r;

  // Round-robin: on a tie the requester not served last wins.
  always_comb begin
    if (req_valid == 2'b11) begin
      grant_s = ~last_r;
    end else begin
      grant_s = req_valid[1];
    end
  end

  // Last-served pointer; reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_r <= 1'b1;
    end else if (accept_s) begin
      last_r <= grant_s;
    end else begin
      last_r <= last_r;
    end
  end
`endif

  // Handshake, operand mux and per-pass step size.
  always_comb begin
    accept_s    = (state_r == IDLE) && req_valid[grant_s];
    req_ready   = accept_s ? (grant_s ? 2'b10 : 2'b01) : 2'b00;
    req_data_s  = grant_s ? req_data1 : req_data0;
    req_amt_s   = grant_s ? req_amt1 : req_amt0;
    last_pass_s = !(rem_r > AMT_W'(SHIFT_MAX));
    if (last_pass_s) begin
      step_s = rem_r[2:0];
    end else begin
      step_s = 3'(SHIFT_MAX);
    end
  end

  barrel_shifter_gate u_shifter (
    .data   (op_r),
    .amt    (step_s),
    .result (shift_res_s)
  );

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (last_pass_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, working operand, remaining amount and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      op_r        <= {DATA_W{1'b0}};
      rem_r       <= {AMT_W{1'b0}};
      id_r        <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      out_id_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      if (accept_s) begin
        op_r  <= req_data_s;
        rem_r <= req_amt_s;
        id_r  <= grant_s;
      end else if (state_r == SHIFT) begin
        op_r  <= shift_res_s;
        rem_r <= rem_r - AMT_W'(step_s);
      end else begin
        op_r  <= op_r;
        rem_r <= rem_r;
      end
      // Result is captured on the final pass and held through back-pressure.
      if ((state_r == SHIFT) && last_pass_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= shift_res_s;
        out_id_r    <= id_r;
      end else if ((state_r == DONE) && out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_id    = out_id_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_barrel_arbiter.sv
// Scoreboard bench for barrel_arbiter: model results queued at accept, compared at output handshake.
module tb_barrel_arbiter;

  localparam int AMT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req_valid = 2'b00;
  logic [1:0]       req_ready;
  logic [7:0]       req_data0 = 8'h00;
  logic [7:0]       req_data1 = 8'h00;
  logic [AMT_W-1:0] req_amt0 = '0;
  logic [AMT_W-1:0] req_amt1 = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [7:0]       out_data;
  logic             out_id;
  logic             busy;

  typedef struct {
    logic [7:0] data;
    logic       id;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  logic grant_log[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  logic model_last = 1'b1;
  logic prev_valid = 1'b0;

  barrel_arbiter #(.AMT_W(AMT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_amt0  (req_amt0),
    .req_amt1  (req_amt1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model_shift(input logic [7:0] d, input logic [AMT_W-1:0] a);
    logic [31:0] w;
    w = {24'd0, d} << a;
    return w[7:0];
  endfunction

  function automatic int passes(input logic [AMT_W-1:0] a);
    return (a == 0) ? 1 : (int'(a) + 6) / 7;
  endfunction

  // Monitor: grant model and scoreboard push at accept, latency and data check at output.
  always @(negedge clk) begin : monitor
    logic       g;
    logic       eg;
    logic [7:0] d;
    logic [AMT_W-1:0] a;
    exp_t       e;
    if (rst_n) begin
      if (req_ready != 2'b00) begin
`ifdef BARREL_ARB_FIXED_PRIO_EN
        eg = (req_valid == 2'b11) ? 1'b0 : req_valid[1];
`else
        eg = (req_valid == 2'b11) ? ~model_last : req_valid[1];
`endif
        check("grant", {30'd0, req_ready}, eg ? 32'd2 : 32'd1);
        g = req_ready[1];
        d = g ? req_data1 : req_data0;
        a = g ? req_amt1 : req_amt0;
        model_last <= g;
        acc_cnt    <= acc_cnt + 1;
        grant_log.push_back(g);
        sb_q.push_back('{data: model_shift(d, a), id: g, cyc: cyc + 1 + passes(a)});
      end
      if (out_valid && !prev_valid) begin
        check("valid_expected", {31'd0, sb_q.size() != 0}, 32'd1);
        if (sb_q.size() != 0) check("latency", cyc, sb_q[0].cyc);
      end
      if (out_valid && out_ready) begin
        check("out_expected", {31'd0, sb_q.size() != 0}, 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("out_data", {24'd0, out_data}, {24'd0, e.data});
          check("out_id", {31'd0, out_id}, {31'd0, e.id});
        end
      end
      prev_valid <= out_valid;
    end else begin
      prev_valid <= 1'b0;
      model_last <= 1'b1;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    sb_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic issue(input int id, input logic [7:0] d, input logic [AMT_W-1:0] a);
    logic got;
    got = 1'b0;
    @(posedge clk);
    #1;
    if (id == 0) begin
      req_data0 = d;
      req_amt0  = a;
    end else begin
      req_data1 = d;
      req_amt1  = a;
    end
    req_valid[id] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        got = 1'b1;
        break;
      end
    end
    check("accept_seen", {31'd0, got}, 32'd1);
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    check("drain", {31'd0, done}, 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int         base;
    logic       seen;
    logic [7:0] exp_bp;
    logic       exp_seq[4];

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_id", {31'd0, out_id}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_req_ready", {30'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    issue(0, 8'h03, 4'd5);  drain();
    issue(1, 8'hFF, 4'd15); drain();
    issue(0, 8'h01, 4'd9);  drain();
    issue(1, 8'hA5, 4'd0);  drain();
    issue(0, 8'h81, 4'd1);  drain();
    issue(1, 8'hFF, 4'd7);  drain();
    issue(0, 8'h01, 4'd8);  drain();
    issue(1, 8'h01, 4'd14); drain();
    issue(0, 8'h01, 4'd7);  drain();

    // Back-pressure in DONE with both requesters waiting.
    out_ready = 1'b0;
    issue(0, 8'h5A, 4'd3);
    req_valid = 2'b11;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("bp_valid_seen", {31'd0, seen}, 32'd1);
    exp_bp = model_shift(8'h5A, 4'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_data", {24'd0, out_data}, {24'd0, exp_bp});
      check("bp_id", {31'd0, out_id}, 32'd0);
      check("bp_req_ready", {30'd0, req_ready}, 32'd0);
      check("bp_busy", {31'd0, busy}, 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    req_valid = 2'b00;
    drain();

    // Reset during a multi-pass transaction.
    issue(1, 8'hFF, 4'd15);
    rst_n = 1'b0;
    sb_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data", {24'd0, out_data}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_req_ready", {30'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(0, 8'h11, 4'd2);
    drain();

    // Arbitration with both requesters held valid.
    do_reset();
    grant_log.delete();
    base = acc_cnt;
    req_data0 = 8'h01;
    req_amt0  = 4'd1;
    req_data1 = 8'h01;
    req_amt1  = 4'd2;
    @(posedge clk);
    #1 req_valid = 2'b11;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (acc_cnt >= base + 4) begin
        seen = 1'b1;
        break;
      end
    end
    #1 req_valid = 2'b00;
    check("arb_four_accepts", {31'd0, seen}, 32'd1);
    drain();
`ifdef BARREL_ARB_FIXED_PRIO_EN
    exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    check("arb_log_len", grant_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
      check($sformatf("arb_seq%0d", i), {31'd0, grant_log[i]}, {31'd0, exp_seq[i]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
